// File: rtl/exec_core_pkg.sv
// Shared opcode encodings and ALU operation enum for exec_core.
// The optional shifter is enabled with the EXEC_CORE_SHIFT_EN macro.
package exec_core_pkg;

  localparam int DATA_W = 32;

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b00001;
  localparam logic [4:0] OP_AND   = 5'b00010;
  localparam logic [4:0] OP_OR    = 5'b00011;
  localparam logic [4:0] OP_XOR   = 5'b00100;
  localparam logic [4:0] OP_SHL   = 5'b00101;
  localparam logic [4:0] OP_SHR   = 5'b00110;
  localparam logic [4:0] OP_JMP   = 5'b00111;
  localparam logic [4:0] OP_INC   = 5'b01000;
  localparam logic [4:0] OP_DEC   = 5'b01001;
  localparam logic [4:0] OP_LOAD  = 5'b01010;
  localparam logic [4:0] OP_BEQ   = 5'b01011;
  localparam logic [4:0] OP_STORE = 5'b01100;
  localparam logic [4:0] OP_LDI   = 5'b01101;
  localparam logic [4:0] OP_ADDM  = 5'b01110;
  localparam logic [4:0] OP_HALT  = 5'b11111;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SHL,
    ALU_SHR
  } alu_op_e;

endpackage

// File: rtl/exec_core_alu.sv
// Purely combinational 32-bit ALU producing result and {V,C,Z,S} status.
module exec_core_alu
  import exec_core_pkg::*;
(
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  alu_op_e                  op,
  output logic signed [DATA_W-1:0] result,
  output logic                     v,
  output logic                     c,
  output logic                     z,
  output logic                     s
);

  logic [DATA_W-1:0] ua;
  logic [DATA_W-1:0] ub;
  logic [DATA_W:0]   sum_w;
  logic [DATA_W:0]   diff_w;

  always_comb begin
    ua     = a;
    ub     = b;
    sum_w  = {1'b0, ua} + {1'b0, ub};
    diff_w = {1'b0, ua} - {1'b0, ub};
    result = '0;
    v      = 1'b0;
    c      = 1'b0;
    case (op)
      ALU_ADD: begin
        result = $signed(sum_w[DATA_W-1:0]);
        c      = sum_w[DATA_W];
        v      = (a[DATA_W-1] == b[DATA_W-1]) && (sum_w[DATA_W-1] != a[DATA_W-1]);
      end
      // Borrow out of the 33-bit difference is exactly the unsigned a<b test.
      ALU_SUB: begin
        result = $signed(diff_w[DATA_W-1:0]);
        c      = diff_w[DATA_W];
        v      = (a[DATA_W-1] != b[DATA_W-1]) && (diff_w[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SHL: result = $signed(ua << ub[4:0]);
      ALU_SHR: result = $signed(ua >> ub[4:0]);
      default: result = '0;
    endcase
    z = (result == '0);
    s = result[DATA_W-1];
  end

endmodule

// File: rtl/exec_core.sv
// Single-cycle execute stage: decode, ALU, data/instruction memories, flags.
// Define EXEC_CORE_SHIFT_EN to implement SHL/SHR; otherwise they act as NOP.
module exec_core
  import exec_core_pkg::*;
#(
  parameter int DMEM_AW = 10,
  parameter int IMEM_AW = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         pc,
  input  logic signed [31:0]  reg_data1,
  input  logic signed [31:0]  reg_data2,
  input  logic                ins_mem_write,
  input  logic [IMEM_AW-1:0]  ins_wr_addr,
  input  logic [31:0]         ins_wr_data,
  output logic [31:0]         ir,
  output logic signed [31:0]  alu_result,
  output logic [3:0]          flags,
  output logic                wb_en,
  output logic [4:0]          wb_addr,
  output logic [31:0]         wb_data,
  output logic [31:0]         next_pc,
  output logic                halt
);

  logic [31:0] imem_q [0:(1<<IMEM_AW)-1];
  logic [31:0] dmem_q [0:(1<<DMEM_AW)-1];

  logic [4:0]  opcode;
  logic [4:0]  rs1;
  logic [4:0]  rd;
  logic [21:0] imm22;

  logic [DMEM_AW-1:0] dmem_rd_a_addr;
  logic [DMEM_AW-1:0] dmem_rd_b_addr;
  logic [31:0]        dmem_rd_a;
  logic [31:0]        dmem_rd_b;
  logic               dmem_we;

  alu_op_e            alu_op;
  logic signed [31:0] alu_a;
  logic signed [31:0] alu_b;
  logic signed [31:0] alu_res;
  logic               alu_v;
  logic               alu_c;
  logic               alu_z;
  logic               alu_s;

  logic               flag_ld;
  logic [3:0]         flags_d;
  logic [3:0]         flags_q;

  assign ir     = imem_q[pc[IMEM_AW-1:0]];
  assign opcode = ir[31:27];
  assign rs1    = ir[26:22];
  assign rd     = ir[16:12];
  assign imm22  = ir[21:0];

  // LOAD addresses port A by immediate; ADDM addresses both ports by register.
  assign dmem_rd_a_addr = (opcode == OP_LOAD) ? imm22[DMEM_AW-1:0] : reg_data1[DMEM_AW-1:0];
  assign dmem_rd_b_addr = reg_data2[DMEM_AW-1:0];
  assign dmem_rd_a      = dmem_q[dmem_rd_a_addr];
  assign dmem_rd_b      = dmem_q[dmem_rd_b_addr];

  always_comb begin
    alu_op = ALU_ADD;
    alu_a  = reg_data1;
    alu_b  = reg_data2;
    case (opcode)
      OP_SUB, OP_BEQ: alu_op = ALU_SUB;
      OP_AND:         alu_op = ALU_AND;
      OP_OR:          alu_op = ALU_OR;
      OP_XOR:         alu_op = ALU_XOR;
`ifdef EXEC_CORE_SHIFT_EN
      OP_SHL:         alu_op = ALU_SHL;
      OP_SHR:         alu_op = ALU_SHR;
`endif
      OP_INC:         alu_b  = 32'sd1;
      OP_DEC: begin
        alu_op = ALU_SUB;
        alu_b  = 32'sd1;
      end
      OP_ADDM: begin
        alu_a = $signed(dmem_rd_a);
        alu_b = $signed(dmem_rd_b);
      end
      default: ;
    endcase
  end

  exec_core_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_res),
    .v      (alu_v),
    .c      (alu_c),
    .z      (alu_z),
    .s      (alu_s)
  );

  assign alu_result = alu_res;

  always_comb begin
    wb_en   = 1'b0;
    wb_addr = rd;
    wb_data = alu_res;
    flag_ld = 1'b0;
    dmem_we = 1'b0;
    next_pc = pc + 32'd1;
    halt    = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDM: begin
        wb_en   = 1'b1;
        flag_ld = 1'b1;
      end
`ifdef EXEC_CORE_SHIFT_EN
      OP_SHL, OP_SHR: begin
        wb_en   = 1'b1;
        flag_ld = 1'b1;
      end
`endif
      OP_INC, OP_DEC: begin
        wb_en   = 1'b1;
        wb_addr = rs1;
        flag_ld = 1'b1;
      end
      OP_LOAD: begin
        wb_en   = 1'b1;
        wb_addr = rs1;
        wb_data = dmem_rd_a;
      end
      OP_STORE: dmem_we = 1'b1;
      OP_LDI: begin
        wb_en   = 1'b1;
        wb_addr = rs1;
        wb_data = {{10{imm22[21]}}, imm22};
      end
      OP_BEQ: begin
        flag_ld = 1'b1;
        if (alu_z) next_pc = {10'd0, imm22};
      end
      OP_JMP: next_pc = {5'd0, ir[26:0]};
      OP_HALT: begin
        halt    = 1'b1;
        next_pc = pc;
      end
      default: ;
    endcase
  end

  assign flags_d = flag_ld ? {alu_v, alu_c, alu_z, alu_s} : flags_q;
  assign flags   = flags_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) flags_q <= 4'b0000;
    else      flags_q <= flags_d;
  end

  // Memories are never cleared; reset only gates their write enables.
  always_ff @(posedge clk) begin
    if (rst && dmem_we) dmem_q[imm22[DMEM_AW-1:0]] <= reg_data1;
  end

  always_ff @(posedge clk) begin
    if (rst && ins_mem_write) imem_q[ins_wr_addr] <= ins_wr_data;
  end

endmodule

// File: tb/tb_exec_core.sv
// Directed, table-driven bench for exec_core with hand sequences for
// same-cycle instruction-memory writes and mid-operation reset.
module tb_exec_core;

  localparam logic [4:0] T_ADD = 5'b00000, T_SUB = 5'b00001, T_AND = 5'b00010,
                         T_OR = 5'b00011, T_XOR = 5'b00100, T_SHL = 5'b00101,
                         T_SHR = 5'b00110, T_JMP = 5'b00111, T_INC = 5'b01000,
                         T_DEC = 5'b01001, T_LOAD = 5'b01010, T_BEQ = 5'b01011,
                         T_STORE = 5'b01100, T_LDI = 5'b01101, T_ADDM = 5'b01110,
                         T_HALT = 5'b11111, T_NOP = 5'b10000;

  logic               clk = 1'b0;
  logic               rst;
  logic [31:0]        pc;
  logic signed [31:0] reg_data1;
  logic signed [31:0] reg_data2;
  logic               ins_mem_write;
  logic [9:0]         ins_wr_addr;
  logic [31:0]        ins_wr_data;
  logic [31:0]        ir;
  logic signed [31:0] alu_result;
  logic [3:0]         flags;
  logic               wb_en;
  logic [4:0]         wb_addr;
  logic [31:0]        wb_data;
  logic [31:0]        next_pc;
  logic               halt;

  exec_core #(.DMEM_AW(10), .IMEM_AW(10)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc            (pc),
    .reg_data1     (reg_data1),
    .reg_data2     (reg_data2),
    .ins_mem_write (ins_mem_write),
    .ins_wr_addr   (ins_wr_addr),
    .ins_wr_data   (ins_wr_data),
    .ir            (ir),
    .alu_result    (alu_result),
    .flags         (flags),
    .wb_en         (wb_en),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .next_pc       (next_pc),
    .halt          (halt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] npc;
    logic        hl;
    logic        fl;
    logic [3:0]  ef;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic [3:0] flags_m = 4'b0000;

  function automatic logic [31:0] enc_r(logic [4:0] op, logic [4:0] rd);
    return {op, 5'd0, 5'd0, rd, 12'd0};
  endfunction

  function automatic logic [31:0] enc_i(logic [4:0] op, logic [4:0] rs1, logic [21:0] imm);
    return {op, rs1, imm};
  endfunction

  function automatic vec_t mk(logic [31:0] ins, logic [31:0] p, logic [31:0] r1,
                              logic [31:0] r2, logic we, logic [4:0] wa,
                              logic [31:0] wd, logic [31:0] npc, logic hl,
                              logic fl, logic [3:0] ef);
    vec_t v;
    v.ins = ins; v.pc = p; v.r1 = r1; v.r2 = r2; v.we = we; v.wa = wa;
    v.wd = wd; v.npc = npc; v.hl = hl; v.fl = fl; v.ef = ef;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_ins(logic [9:0] addr, logic [31:0] word);
    @(negedge clk);
    ins_mem_write = 1'b1;
    ins_wr_addr   = addr;
    ins_wr_data   = word;
    @(negedge clk);
    ins_mem_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w0;
    logic [31:0] w1;
    w0 = enc_i(T_LDI, 5'd2, 22'd5);
    w1 = enc_i(T_LDI, 5'd2, 22'd6);

    rst = 1'b0; pc = 32'h3FF; reg_data1 = '0; reg_data2 = '0;
    ins_mem_write = 1'b0; ins_wr_addr = '0; ins_wr_data = '0;

    //                 ins                                  pc       r1           r2           we wa     wd           npc       hl fl flags
    vecs.push_back(mk(enc_r(T_ADD, 5'd3),                  32'h100, 32'h7FFFFFFF, 32'h1,       1, 5'd3,  32'h80000000, 32'h101, 0, 1, 4'b1001));
    vecs.push_back(mk(enc_r(T_SUB, 5'd4),                  32'h101, 32'd5,        32'd5,       1, 5'd4,  32'h0,        32'h102, 0, 1, 4'b0010));
    vecs.push_back(mk(enc_r(T_SUB, 5'd5),                  32'h102, 32'd0,        32'd1,       1, 5'd5,  32'hFFFFFFFF, 32'h103, 0, 1, 4'b0101));
    vecs.push_back(mk(enc_r(T_AND, 5'd6),                  32'h103, 32'hF0F0F0F0, 32'h0FF00FF0, 1, 5'd6, 32'h00F000F0, 32'h104, 0, 1, 4'b0000));
    vecs.push_back(mk(enc_r(T_OR, 5'd7),                   32'h104, 32'hF0000000, 32'h0000000F, 1, 5'd7, 32'hF000000F, 32'h105, 0, 1, 4'b0001));
    vecs.push_back(mk(enc_r(T_XOR, 5'd8),                  32'h105, 32'hAAAAAAAA, 32'hAAAAAAAA, 1, 5'd8, 32'h0,        32'h106, 0, 1, 4'b0010));
    vecs.push_back(mk(enc_r(T_ADD, 5'd9),                  32'h106, 32'hFFFFFFFF, 32'h1,       1, 5'd9,  32'h0,        32'h107, 0, 1, 4'b0110));
    vecs.push_back(mk(enc_i(T_INC, 5'd10, 22'h0),          32'h107, 32'h7FFFFFFF, 32'h55,      1, 5'd10, 32'h80000000, 32'h108, 0, 1, 4'b1001));
    vecs.push_back(mk(enc_i(T_DEC, 5'd11, 22'h0),          32'h108, 32'h0,        32'h55,      1, 5'd11, 32'hFFFFFFFF, 32'h109, 0, 1, 4'b0101));
    vecs.push_back(mk(enc_i(T_DEC, 5'd19, 22'h0),          32'h109, 32'h80000000, 32'h0,       1, 5'd19, 32'h7FFFFFFF, 32'h10A, 0, 1, 4'b1000));
    vecs.push_back(mk(enc_i(T_LDI, 5'd12, 22'h3FFFFF),     32'h10A, 32'h0,        32'h0,       1, 5'd12, 32'hFFFFFFFF, 32'h10B, 0, 0, 4'b0000));
    vecs.push_back(mk(enc_i(T_LDI, 5'd13, 22'h1FFFFF),     32'h10B, 32'h0,        32'h0,       1, 5'd13, 32'h001FFFFF, 32'h10C, 0, 0, 4'b0000));
    vecs.push_back(mk(enc_i(T_STORE, 5'd1, 22'd7),         32'h10C, 32'h1234,     32'h0,       0, 5'd0,  32'h0,        32'h10D, 0, 0, 4'b0000));
    vecs.push_back(mk(enc_i(T_LOAD, 5'd14, 22'd7),         32'h10D, 32'h0,        32'h0,       1, 5'd14, 32'h1234,     32'h10E, 0, 0, 4'b0000));
    vecs.push_back(mk(enc_i(T_LOAD, 5'd15, 22'h407),       32'h10E, 32'h0,        32'h0,       1, 5'd15, 32'h1234,     32'h10F, 0, 0, 4'b0000));
    vecs.push_back(mk(enc_i(T_STORE, 5'd1, 22'd8),         32'h10F, 32'h10,       32'h0,       0, 5'd0,  32'h0,        32'h110, 0, 0, 4'b0000));
    vecs.push_back(mk(enc_r(T_ADDM, 5'd16),                32'h110, 32'h407,      32'h8,       1, 5'd16, 32'h1244,     32'h111, 0, 1, 4'b0000));
    vecs.push_back(mk(enc_i(T_BEQ, 5'd0, 22'h40),          32'h111, 32'h55,       32'h55,      0, 5'd0,  32'h0,        32'h40,  0, 1, 4'b0010));
    vecs.push_back(mk(enc_i(T_BEQ, 5'd0, 22'h40),          32'h010, 32'd3,        32'd5,       0, 5'd0,  32'h0,        32'h11,  0, 1, 4'b0101));
    vecs.push_back(mk({T_JMP, 27'h2345678},                32'h112, 32'h0,        32'h0,       0, 5'd0,  32'h0,        32'h02345678, 0, 0, 4'b0000));
    vecs.push_back(mk({T_HALT, 27'h0},                     32'h113, 32'h0,        32'h0,       0, 5'd0,  32'h0,        32'h113, 1, 0, 4'b0000));
    vecs.push_back(mk({T_NOP, 27'h0},                      32'h114, 32'h1,        32'h2,       0, 5'd0,  32'h0,        32'h115, 0, 0, 4'b0000));
`ifdef EXEC_CORE_SHIFT_EN
    vecs.push_back(mk(enc_r(T_SHL, 5'd17),                 32'h115, 32'h1,        32'h24,      1, 5'd17, 32'h10,       32'h116, 0, 1, 4'b0000));
    vecs.push_back(mk(enc_r(T_SHR, 5'd18),                 32'h116, 32'h80000000, 32'h1F,      1, 5'd18, 32'h1,        32'h117, 0, 1, 4'b0000));
`else
    vecs.push_back(mk(enc_r(T_SHL, 5'd17),                 32'h115, 32'h1,        32'h24,      0, 5'd0,  32'h0,        32'h116, 0, 0, 4'b0000));
    vecs.push_back(mk(enc_r(T_SHR, 5'd18),                 32'h116, 32'h80000000, 32'h1F,      0, 5'd0,  32'h0,        32'h117, 0, 0, 4'b0000));
`endif

    repeat (2) @(posedge clk);
    #1 check("reset_flags", {28'd0, flags}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    load_ins(10'h3FF, {T_NOP, 27'h0});
    foreach (vecs[i]) load_ins(vecs[i].pc[9:0], vecs[i].ins);
    load_ins(10'h200, w0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      pc        = vecs[i].pc;
      reg_data1 = vecs[i].r1;
      reg_data2 = vecs[i].r2;
      #1;
      check($sformatf("v%0d_ir", i), ir, vecs[i].ins);
      check($sformatf("v%0d_wb_en", i), {31'd0, wb_en}, {31'd0, vecs[i].we});
      if (vecs[i].we) begin
        check($sformatf("v%0d_wb_addr", i), {27'd0, wb_addr}, {27'd0, vecs[i].wa});
        check($sformatf("v%0d_wb_data", i), wb_data, vecs[i].wd);
      end
      check($sformatf("v%0d_next_pc", i), next_pc, vecs[i].npc);
      check($sformatf("v%0d_halt", i), {31'd0, halt}, {31'd0, vecs[i].hl});
      @(posedge clk);
      #1;
      if (vecs[i].fl) flags_m = vecs[i].ef;
      check($sformatf("v%0d_flags", i), {28'd0, flags}, {28'd0, flags_m});
    end

    // Same-cycle fetch of an instruction word being rewritten sees the old word.
    @(negedge clk);
    pc = 32'h200; reg_data1 = '0; reg_data2 = '0;
    ins_mem_write = 1'b1; ins_wr_addr = 10'h200; ins_wr_data = w1;
    #1;
    check("imem_old_ir", ir, w0);
    check("imem_old_wb", wb_data, 32'd5);
    @(posedge clk);
    #1;
    check("imem_new_ir", ir, w1);
    check("imem_new_wb", wb_data, 32'd6);
    @(negedge clk);
    ins_mem_write = 1'b0; pc = 32'h3FF;

    // Set flags nonzero, then assert reset mid-cycle with a STORE and imem write pending.
    @(negedge clk);
    pc = 32'h100; reg_data1 = 32'h7FFFFFFF; reg_data2 = 32'h1;
    @(posedge clk);
    #1 check("pre_rst_flags", {28'd0, flags}, 32'h9);
    @(negedge clk);
    pc = 32'h10C; reg_data1 = 32'hDEAD;
    ins_mem_write = 1'b1; ins_wr_addr = 10'h200; ins_wr_data = 32'hFFFFFFFF;
    rst = 1'b0;
    #1;
    check("rst_flags_async", {28'd0, flags}, 32'h0);
    check("rst_ir_follows", ir, enc_i(T_STORE, 5'd1, 22'd7));
    @(posedge clk);
    #1 check("rst_flags_held", {28'd0, flags}, 32'h0);
    @(negedge clk);
    ins_mem_write = 1'b0; pc = 32'h3FF; rst = 1'b1;
    @(negedge clk);
    pc = 32'h10D;
    #1 check("rst_dmem_kept", wb_data, 32'h1234);
    pc = 32'h200;
    #1 check("rst_imem_kept", ir, w1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/exec_core.md
EXEC_CORE -- requirements
Module: exec_core

Interface
REQ-001 Param DMEM_AW, 10, data-memory address bits (2**DMEM_AW words of 32 bits).
REQ-002 Param IMEM_AW, 10, instruction-memory address bits (2**IMEM_AW words of 32 bits).
REQ-003 Clock and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 pc  in  32  fetch address; word index pc[IMEM_AW-1:0].
REQ-007 reg_data1, reg_data2  in  32 signed  register-file values selected by ir[26:22] and ir[21:17].
REQ-008 ins_mem_write  in  1; ins_wr_addr  in  IMEM_AW; ins_wr_data  in  32: instruction-memory write port.
REQ-009 ir  out  32  instruction at pc.
REQ-010 alu_result  out  32 signed  combinational ALU output.
REQ-011 flags  out  4  registered {V,C,Z,S}.
REQ-012 wb_en  out  1; wb_addr  out  5; wb_data  out  32: register write-back request.
REQ-013 next_pc  out  32  PC for the next cycle; halt  out  1  HALT decoded.

Function
REQ-014 opcode = ir[31:27]; imm22 = ir[21:0]; rd = ir[16:12]; rs1 = ir[26:22].
REQ-015 ADD 00000, SUB 00001, AND 00010, OR 00011, XOR 00100, SHL 00101, SHR 00110 SHALL write alu(reg_data1, reg_data2) to rd.
REQ-016 INC 01000 and DEC 01001 SHALL write reg_data1+1 and reg_data1-1 to rs1.
REQ-017 LOAD 01001? no: LOAD 01010 SHALL write dmem[imm22] to rs1; STORE 01100 SHALL write reg_data1 to dmem[imm22].
REQ-018 LDI 01101 SHALL write sign-extended imm22 to rs1; ADDM 01110 SHALL write dmem[reg_data1]+dmem[reg_data2] to rd.
REQ-019 BEQ 01011 SHALL compute reg_data1-reg_data2 and set next_pc = zero-extended imm22 when the result is 0, else pc+1.
REQ-020 JMP 00111 SHALL set next_pc = zero-extended ir[26:0]; HALT 11111 SHALL assert halt and set next_pc = pc.
REQ-021 All other opcodes, including NOP, SHALL set next_pc = pc+1 and perform no writes.
REQ-022 ADD: C = unsigned carry-out, V = signed overflow. SUB/DEC/BEQ: C = unsigned borrow (a<b), V = signed overflow. Logic ops and shifts: C = V = 0.
REQ-023 Z = (result==0) and S = result[31] for every ALU op; shift amount = operand2[4:0]; SHR is logical.
REQ-024 flags SHALL load on the rising edge for opcodes 00000-00110, 01000, 01001, 01011 and 01110, and hold otherwise.
REQ-025 wb_en, wb_addr, wb_data, alu_result, ir and next_pc SHALL be combinational (0 latency).
REQ-026 Data memory SHALL have two combinational read ports and one write port that writes synchronously on the rising edge.
REQ-027 A read of an address being written in the same cycle SHALL return the old value; the new value is visible after the edge.
REQ-028 Memory addresses SHALL wrap modulo depth (upper bits ignored).
REQ-029 Instruction memory SHALL write ins_wr_data on the rising edge when ins_mem_write=1; a same-cycle fetch of that address returns the old word.

Reset
REQ-030 While rst=0: flags=0; dmem and imem writes are suppressed; memory contents are preserved.
REQ-031 Reset assertion mid-operation SHALL clear flags immediately; combinational outputs keep following their inputs.

Configuration
REQ-032 With EXEC_CORE_SHIFT_EN defined, SHL and SHR SHALL be implemented; without it they SHALL behave as NOP: no write-back, no flag update, next_pc = pc+1.

Structure
REQ-033 Opcode localparams and the ALU-op enum SHALL live in the shared package exec_core_pkg.
REQ-034 The ALU SHALL be the single sub-module, exec_core_alu: purely combinational, with operands, op and {result, V, C, Z, S}.

Verification
REQ-035 ADD 0x7FFFFFFF+1 -> wb_data=0x80000000, wb_addr=rd; after the edge flags: V=1, C=0, Z=0, S=1.
REQ-036 SUB 5-5 -> wb_data=0; after the edge Z=1, C=0. SUB 0-1 -> wb_data=0xFFFFFFFF, C=1, S=1.
REQ-037 STORE reg_data1=0x1234 to imm22=7, then LOAD imm22=7 -> wb_data=0x1234, wb_addr=rs1.
REQ-038 BEQ with equal operands and imm22=0x40 -> next_pc=0x40; with unequal operands and pc=0x10 -> next_pc=0x11.
REQ-039 LDI imm22=0x3FFFFF -> wb_data=0xFFFFFFFF. HALT -> halt=1 and next_pc=pc.
REQ-040 Drive rst=0 while flags are nonzero and mem_write is active -> flags=0 immediately and dmem is unchanged.
